// File: rtl/pulse_monitor.sv
// Pulse shape checker: measures high width and rise-to-rise period of a
// single-clock pulse and flags deviations. Optional watchdog: PULSE_MON_TIMEOUT_EN.
`timescale 1ns/1ps

// state | meaning
// IDLE  | no rise seen since reset/clear
// HIGH  | pulse in progress, counting high width
// LOW   | between pulses, counting period
module pulse_monitor #(
  parameter int CNT_W      = 8,
  parameter int EXP_HIGH   = 5,
  parameter int EXP_PERIOD = 40,
  parameter int TOL        = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             pulse_in,
  output logic             pulse_done,
  output logic [CNT_W-1:0] last_high,
  output logic [CNT_W-1:0] last_period,
  output logic             period_valid,
  output logic [15:0]      pulse_count,
  output logic             width_err,
  output logic             period_err,
  output logic             timeout_err
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam int unsigned TOL_U        = TOL;
  localparam int unsigned EXP_HIGH_U   = EXP_HIGH;
  localparam int unsigned EXP_PERIOD_U = EXP_PERIOD;

  state_t           state, state_nx;
  logic             pulse_d;
  logic             rise, fall;
  logic [CNT_W-1:0] high_cnt, high_nx;
  logic [CNT_W-1:0] per_cnt, per_nx;
  logic [CNT_W-1:0] last_high_nx, last_period_nx;
  logic             period_valid_nx, pulse_done_nx;
  logic [15:0]      pulse_count_nx;
  logic             width_err_nx, period_err_nx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Unsigned window test written so that neither side can wrap.
  function automatic logic off_nominal(input logic [CNT_W-1:0] val, input int unsigned expv);
    int unsigned v;
    v = {{(32-CNT_W){1'b0}}, val};
    return (v > expv + TOL_U) || (v + TOL_U < expv);
  endfunction

  assign rise = pulse_in & ~pulse_d;
  assign fall = ~pulse_in & pulse_d;

  always_comb begin
    state_nx        = state;
    high_nx         = high_cnt;
    per_nx          = per_cnt;
    last_high_nx    = last_high;
    last_period_nx  = last_period;
    period_valid_nx = period_valid;
    pulse_count_nx  = pulse_count;
    width_err_nx    = width_err;
    period_err_nx   = period_err;
    pulse_done_nx   = 1'b0;
    if (clear) begin
      state_nx        = IDLE;
      high_nx         = '0;
      per_nx          = '0;
      last_high_nx    = '0;
      last_period_nx  = '0;
      period_valid_nx = 1'b0;
      pulse_count_nx  = '0;
      width_err_nx    = 1'b0;
      period_err_nx   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_nx = HIGH;
            high_nx  = CNT_ONE;
            per_nx   = CNT_ONE;
          end
        end
        HIGH: begin
          per_nx = sat_inc(per_cnt);
          if (pulse_in) high_nx = sat_inc(high_cnt);
          if (fall) begin
            last_high_nx   = high_cnt;
            pulse_count_nx = (pulse_count == 16'hFFFF) ? pulse_count : pulse_count + 16'd1;
            pulse_done_nx  = 1'b1;
            if (off_nominal(high_cnt, EXP_HIGH_U)) width_err_nx = 1'b1;
            state_nx = LOW;
          end
        end
        LOW: begin
          if (rise) begin
            last_period_nx  = per_cnt;
            period_valid_nx = 1'b1;
            if (off_nominal(per_cnt, EXP_PERIOD_U)) period_err_nx = 1'b1;
            per_nx   = CNT_ONE;
            high_nx  = CNT_ONE;
            state_nx = HIGH;
          end else begin
            per_nx = sat_inc(per_cnt);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pulse_d      <= 1'b0;
      high_cnt     <= '0;
      per_cnt      <= '0;
      last_high    <= '0;
      last_period  <= '0;
      period_valid <= 1'b0;
      pulse_count  <= '0;
      width_err    <= 1'b0;
      period_err   <= 1'b0;
      pulse_done   <= 1'b0;
    end else begin
      state        <= state_nx;
      pulse_d      <= pulse_in;
      high_cnt     <= high_nx;
      per_cnt      <= per_nx;
      last_high    <= last_high_nx;
      last_period  <= last_period_nx;
      period_valid <= period_valid_nx;
      pulse_count  <= pulse_count_nx;
      width_err    <= width_err_nx;
      period_err   <= period_err_nx;
      pulse_done   <= pulse_done_nx;
    end
  end

`ifdef PULSE_MON_TIMEOUT_EN
  localparam int WD_LIM_I = 2 * EXP_PERIOD;
  localparam int WD_PRE_I = WD_LIM_I - 1;
  localparam logic [CNT_W:0] WD_LIMIT = WD_LIM_I[CNT_W:0];
  localparam logic [CNT_W:0] WD_PRE   = WD_PRE_I[CNT_W:0];
  localparam logic [CNT_W:0] WD_ONE   = {{CNT_W{1'b0}}, 1'b1};

  logic [CNT_W:0] wd_cnt, wd_nx;
  logic           timeout_q, timeout_nx;

  // Watchdog only advances while waiting for the next rise; it parks at the limit.
  always_comb begin
    wd_nx      = wd_cnt;
    timeout_nx = timeout_q;
    if (clear) begin
      wd_nx      = '0;
      timeout_nx = 1'b0;
    end else if (state == LOW) begin
      if (rise) begin
        wd_nx = '0;
      end else if (wd_cnt != WD_LIMIT) begin
        wd_nx = wd_cnt + WD_ONE;
        if (wd_cnt == WD_PRE) timeout_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt    <= wd_nx;
      timeout_q <= timeout_nx;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_monitor.sv
// Bench for pulse_monitor: timestamp-based reference model, per-cycle compare,
// directed scenarios plus randomized pulse trains.
`timescale 1ns/1ps

module tb_pulse_monitor;
  localparam int CNT_W      = 8;
  localparam int EXP_HIGH   = 5;
  localparam int EXP_PERIOD = 40;
  localparam int TOL        = 0;
  localparam int MAXV       = (1 << CNT_W) - 1;
`ifdef PULSE_MON_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             pulse_in = 1'b0;
  logic             pulse_done;
  logic [CNT_W-1:0] last_high;
  logic [CNT_W-1:0] last_period;
  logic             period_valid;
  logic [15:0]      pulse_count;
  logic             width_err, period_err, timeout_err;

  always #50 clk = ~clk;

  pulse_monitor #(.CNT_W(CNT_W), .EXP_HIGH(EXP_HIGH), .EXP_PERIOD(EXP_PERIOD), .TOL(TOL)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .pulse_in(pulse_in),
    .pulse_done(pulse_done), .last_high(last_high), .last_period(last_period),
    .period_valid(period_valid), .pulse_count(pulse_count),
    .width_err(width_err), .period_err(period_err), .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: works on edge timestamps of rises and falls.
  int t = 0;
  bit m_pd, m_armed, m_in, m_done, m_pv, m_we, m_pe, m_te;
  int m_rise_t, m_fall_t, m_lh, m_lp, m_cnt;

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  function automatic bit off(input int v, input int e);
    return (v > e + TOL) || (v + TOL < e);
  endfunction

  task automatic model_reset();
    m_pd = 0; m_armed = 0; m_in = 0; m_done = 0; m_pv = 0;
    m_we = 0; m_pe = 0; m_te = 0; m_lh = 0; m_lp = 0; m_cnt = 0;
    m_rise_t = 0; m_fall_t = 0;
  endtask

  task automatic model_edge(input bit pi, input bit clr);
    bit rise, fall;
    rise = pi && !m_pd;
    fall = !pi && m_pd;
    m_done = 0;
    if (clr) begin
      m_armed = 0; m_in = 0; m_lh = 0; m_lp = 0; m_pv = 0;
      m_cnt = 0; m_we = 0; m_pe = 0; m_te = 0;
    end else if (rise) begin
      if (m_armed) begin
        m_lp = sat(t - m_rise_t);
        m_pv = 1;
        if (off(m_lp, EXP_PERIOD)) m_pe = 1;
      end
      m_armed = 1; m_in = 1; m_rise_t = t;
    end else if (fall && m_in) begin
      m_lh = sat(t - m_rise_t);
      if (m_cnt < 65535) m_cnt++;
      m_done = 1;
      if (off(m_lh, EXP_HIGH)) m_we = 1;
      m_in = 0; m_fall_t = t;
    end else if (TO_EN && m_armed && !m_in && (t - m_fall_t == 2 * EXP_PERIOD)) begin
      m_te = 1;
    end
    m_pd = pi;
    t++;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("pulse_done",   {31'b0, pulse_done},   {31'b0, m_done});
      check("last_high",    {24'b0, last_high},    m_lh);
      check("last_period",  {24'b0, last_period},  m_lp);
      check("period_valid", {31'b0, period_valid}, {31'b0, m_pv});
      check("pulse_count",  {16'b0, pulse_count},  m_cnt);
      check("width_err",    {31'b0, width_err},    {31'b0, m_we});
      check("period_err",   {31'b0, period_err},   {31'b0, m_pe});
      check("timeout_err",  {31'b0, timeout_err},  {31'b0, m_te});
    end
  end

  // Entered just after a negedge; returns at the following negedge.
  task automatic step(input bit pi, input bit clr);
    pulse_in = pi;
    clear    = clr;
    @(posedge clk);
    model_edge(pi, clr);
    @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    repeat (hi) step(1'b1, 1'b0);
    repeat (lo) step(1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done"},  {31'b0, pulse_done},   0);
    check({tag, "_high"},  {24'b0, last_high},    0);
    check({tag, "_per"},   {24'b0, last_period},  0);
    check({tag, "_pv"},    {31'b0, period_valid}, 0);
    check({tag, "_cnt"},   {16'b0, pulse_count},  0);
    check({tag, "_werr"},  {31'b0, width_err},    0);
    check({tag, "_perr"},  {31'b0, period_err},   0);
    check({tag, "_terr"},  {31'b0, timeout_err},  0);
  endtask

  // Asynchronous reset pulse placed away from both clock edges.
  task automatic mid_reset(input string tag);
    #10 rst_n = 1'b0;
    model_reset();
    #1 check_all_zero(tag);
    @(posedge clk);
    @(negedge clk);
    #10 rst_n = 1'b1;
  endtask

  initial begin
    int hi, lo;
    bit c;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    #10 rst_n = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;

    // Single pulse
    repeat (10) step(1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("t1_done", {31'b0, pulse_done}, 1);
    check("t1_high", {24'b0, last_high}, 5);
    check("t1_model_high", m_lh, 5);
    check("t1_cnt", {16'b0, pulse_count}, 1);
    check("t1_pv", {31'b0, period_valid}, 0);
    check("t1_werr", {31'b0, width_err}, 0);
    step(1'b0, 1'b0);
    check("t1_done_gone", {31'b0, pulse_done}, 0);
    repeat (23) step(1'b0, 1'b0);
    step(1'b0, 1'b1);

    // Periodic nominal train
    repeat (4) pulse(5, 35);
    check("t2_period", {24'b0, last_period}, 40);
    check("t2_model_period", m_lp, 40);
    check("t2_pv", {31'b0, period_valid}, 1);
    check("t2_cnt", {16'b0, pulse_count}, 4);
    check("t2_werr", {31'b0, width_err}, 0);
    check("t2_perr", {31'b0, period_err}, 0);

    // Wide pulse then short period
    pulse(6, 34);
    check("t3_werr", {31'b0, width_err}, 1);
    check("t3_perr_pre", {31'b0, period_err}, 0);
    pulse(5, 33);
    pulse(5, 35);
    check("t3_period", {24'b0, last_period}, 38);
    check("t3_perr", {31'b0, period_err}, 1);
    check("t3_werr_held", {31'b0, width_err}, 1);
    step(1'b0, 1'b1);
    check_all_zero("t3_clear");

    // Clear in the middle of a pulse
    repeat (5) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    check("t4_cnt_none", {16'b0, pulse_count}, 0);
    pulse(5, 10);
    check("t4_cnt", {16'b0, pulse_count}, 1);
    check("t4_high", {24'b0, last_high}, 5);
    check("t4_pv", {31'b0, period_valid}, 0);

    // Reset mid-pulse, then an overlong pulse
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    mid_reset("t5_rst");
    repeat (300) step(1'b1, 1'b0);
    check("t5_cnt_none", {16'b0, pulse_count}, 0);
    step(1'b0, 1'b0);
    check("t5_high_sat", {24'b0, last_high}, MAXV);
    check("t5_model_sat", m_lh, 255);
    check("t5_werr", {31'b0, width_err}, 1);
    check("t5_cnt", {16'b0, pulse_count}, 1);
    step(1'b0, 1'b1);

    // Watchdog after a single pulse
    repeat (3) step(1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    repeat (79) step(1'b0, 1'b0);
    check("t6_to_early", {31'b0, timeout_err}, 0);
    step(1'b0, 1'b0);
    check("t6_to_fire", {31'b0, timeout_err}, {31'b0, TO_EN});
    repeat (5) step(1'b0, 1'b0);
    check("t6_to_held", {31'b0, timeout_err}, {31'b0, TO_EN});
    step(1'b0, 1'b1);
    repeat (6) pulse(5, 35);
    check("t6_to_periodic", {31'b0, timeout_err}, 0);
    step(1'b0, 1'b1);

    // Randomized trains: mostly near-nominal, some wild, rare clear/reset
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        hi = EXP_HIGH + $urandom_range(0, 2) - 1;
        lo = EXP_PERIOD - hi + $urandom_range(0, 2) - 1;
      end else begin
        hi = ($urandom_range(0, 19) == 0) ? $urandom_range(200, 300) : $urandom_range(1, 8);
        lo = ($urandom_range(0, 9) == 0) ? $urandom_range(80, 120) : $urandom_range(1, 60);
      end
      for (int k = 0; k < hi; k++) begin
        c = ($urandom_range(0, 199) == 0);
        step(1'b1, c);
      end
      for (int k = 0; k < lo; k++) begin
        c = ($urandom_range(0, 199) == 0);
        step(1'b0, c);
      end
      if ($urandom_range(0, 49) == 0) mid_reset("rnd_rst");
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
